// File: rtl/instr_prefetch_rom_if.sv
// Fetch-stream bundle between instr_prefetch_rom (slave) and its consumer (master).
// fetch_count is present only when FETCH_COUNT_EN is defined.
interface instr_prefetch_rom_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W+1:0] redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [ADDR_W+1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic              misalign;
`ifdef FETCH_COUNT_EN
    logic [31:0]       fetch_count;
`endif

    modport master (
        output redirect_valid, redirect_pc, out_ready,
`ifdef FETCH_COUNT_EN
        input  fetch_count,
`endif
        input  out_valid, out_pc, out_instr, misalign
    );

    modport slave (
        input  redirect_valid, redirect_pc, out_ready,
`ifdef FETCH_COUNT_EN
        output fetch_count,
`endif
        output out_valid, out_pc, out_instr, misalign
    );
endinterface

// File: rtl/instr_prefetch_rom.sv
// Program ROM with a sequential prefetch FIFO; redirect flushes and restarts fetch.
// Define FETCH_COUNT_EN to add the 32-bit delivered-instruction counter.
module instr_prefetch_rom #(
    parameter int unsigned       PROGRAM    = 4,
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W+1:0] RESET_PC   = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_prefetch_rom_if.slave bus
);
    localparam int unsigned PC_W  = ADDR_W + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] idx);
        logic [31:0] w;
        int unsigned i;
        i = int'(idx);
        w = NOP;
        case (PROGRAM)
            0: case (i)
                0: w = 32'h0050_0093;
                1: w = 32'h0030_0113;
                2: w = 32'h0020_81b3;
                3: w = 32'h0000_006f;
                default: w = NOP;
            endcase
            1: case (i)
                0: w = 32'h0010_0093;
                1: w = 32'h0010_0113;
                2: w = 32'h0020_81b3;
                3: w = 32'h0001_0093;
                4: w = 32'h0001_8113;
                5: w = 32'hff5f_f06f;
                default: w = NOP;
            endcase
            2: case (i)
                0: w = 32'h1000_0093;
                1: w = 32'h0000_a103;
                2: w = 32'h0011_0113;
                3: w = 32'h0020_a023;
                4: w = 32'hff5f_f06f;
                default: w = NOP;
            endcase
            3: case (i)
                0: w = 32'h1234_50b7;
                1: w = 32'h6780_8093;
                2: w = 32'h0000_006f;
                default: w = NOP;
            endcase
            4: case (i)
                0:  w = 32'h0000_0093;
                1:  w = 32'h0010_0113;
                2:  w = 32'h00a0_0193;
                3:  w = 32'h0020_80b3;
                4:  w = 32'h0011_0113;
                5:  w = 32'hfe31_4ce3;
                6:  w = 32'h0010_2023;
                7:  w = 32'h0000_2203;
                8:  w = 32'h0040_0293;
                9:  w = 32'h0052_0333;
                10: w = 32'h4062_83b3;
                11: w = 32'h0072_f433;
                12: w = 32'h0072_e4b3;
                13: w = 32'h0072_c533;
                14: w = 32'h0022_9593;
                15: w = 32'h0022_d613;
                16: w = 32'h4022_d693;
                17: w = 32'h0062_a733;
                18: w = 32'h0062_b7b3;
                19: w = 32'h0080_0813;
                20: w = 32'h0100_2223;
                21: w = 32'h0040_2883;
                22: w = 32'h0108_8463;
                23: w = 32'h0010_0913;
                24: w = 32'h0000_0993;
                25: w = 32'h00c0_0a6f;
                26: w = 32'h0159_8b33;
                27: w = 32'h016b_8bb3;
                28: w = 32'h0010_0a93;
                29: w = 32'h000a_0b67;
                30: w = 32'h0000_006f;
                31: w = 32'h0000_0073;
                default: w = NOP;
            endcase
            default: w = NOP;
        endcase
        return DATA_W'(w);
    endfunction

    logic [PC_W-1:0]   fetch_pc_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              misalign_q;
    logic [PC_W-1:0]   pc_mem_q    [FIFO_DEPTH];
    logic [DATA_W-1:0] instr_mem_q [FIFO_DEPTH];
    logic              pop;
    logic              issue;

    assign pop = (count_q != '0) && bus.out_ready;
    // The synchronous ROM read lands directly in the FIFO slot, so nothing is ever in flight.
    assign issue = !bus.redirect_valid && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= (bus.redirect_pc[1:0] != 2'b00);
        end else begin
            if (issue) begin
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
                instr_mem_q[wr_ptr_q] <= rom_word(fetch_pc_q[PC_W-1:2]);
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                fetch_pc_q            <= fetch_pc_q + PC_W'(4);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(issue) - CNT_W'(pop);
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
    assign bus.misalign  = misalign_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    // A pop coinciding with a redirect still counts: the consumer took that entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else if (pop) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`endif
endmodule

// File: doc/instr_prefetch_rom.md
Name: instr_prefetch_rom

Overview:
Parametrised instruction memory with a built-in sequential prefetcher for the single-cycle RISC-V core and its successors. It holds a program image selected by parameter, reads it synchronously, and streams (pc, instruction) pairs through a small FIFO with a valid/ready handshake. A redirect input (branch/jump) flushes the FIFO and restarts fetch at a new byte PC.

Parameters:
PROGRAM, 4, index of the built-in program image (0..4); any other value fills the ROM with NOP 0x00000013
ADDR_W, 5, word-address width; ROM depth = 2^ADDR_W words
DATA_W, 32, instruction width
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, byte PC fetched first after reset (word-aligned)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  restart fetch at redirect_pc this cycle
redirect_pc  in  ADDR_W+2  byte PC target
out_ready  in  1  consumer accepts head entry
out_valid  out  1  head entry valid
out_pc  out  ADDR_W+2  byte PC of head instruction
out_instr  out  DATA_W  head instruction
misalign  out  1  last redirect had redirect_pc[1:0] != 0
fetch_count  out  32  delivered-instruction count (only with FETCH_COUNT_EN)

Behaviour:
- Reset (asynchronous, rst_n=0): fetch_pc=RESET_PC; FIFO empty; in-flight read cancelled; out_valid=0, out_pc=0, out_instr=0, misalign=0.
- ROM read is synchronous: address issued in cycle N, data captured in N+1 and pushed with its PC.
- Issue rule: a read is issued in a cycle iff no redirect, and (fifo_count + inflight - pop) < FIFO_DEPTH. pop = out_valid & out_ready. Each issue advances fetch_pc by 4.
- fetch_pc wraps modulo 4*2^ADDR_W (ADDR_W=5: 0x7C -> 0x00).
- Output: out_valid = FIFO non-empty; out_pc/out_instr are the head entry and hold stable while out_valid & !out_ready. The FIFO never overflows and never drops or duplicates an entry.
- Latency: after reset release, the first read issues in cycle 1 and out_valid rises in cycle 2. A stream at out_ready=1 delivers one instruction per cycle.
- Redirect in cycle N:
  - FIFO flushed and in-flight read discarded at the N edge.
  - fetch_pc = {redirect_pc[ADDR_W+1:2], 2'b00}.
  - out_valid=0 in N+1; read of the target issues in N+1; target valid in N+2.
- Redirect simultaneous with pop: the flush wins. The popped entry counts as delivered, since the consumer already sampled it.
- misalign: updated on every redirect to (redirect_pc[1:0] != 0). It holds until the next redirect or reset.
- Reset mid-stream: immediate clear regardless of FIFO state; fetch restarts at RESET_PC.

Optional Feature:
FETCH_COUNT_EN
- With the macro: the 32-bit fetch_count port exists. It resets to 0, increments on each pop, and wraps at 2^32. Redirects do not clear it.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Defaults (PROGRAM=4), reset released, out_ready=1 -> out_valid rises in cycle 2; out_pc 0x00, 0x04, 0x08 on consecutive cycles; out_instr matches image words 0, 1, 2.
2. out_ready=0 for 10 cycles mid-stream -> out_valid stays 1, out_pc/out_instr held, no more than 4 reads issued beyond the head. On release, PCs continue in order with no gap or duplicate.
3. Redirect to 0x40 while FIFO is full -> out_valid=0 next cycle; two cycles after redirect out_pc=0x40, then 0x44; no pre-redirect PC ever appears afterwards.
4. Redirect to 0x7C with out_ready=1 -> sequence 0x7C, 0x00, 0x04 (wrap-around).
5. Redirect to 0x42 -> misalign=1, out_pc=0x40 first. A later redirect to 0x10 -> misalign=0.
6. rst_n pulsed low asynchronously mid-stream -> out_valid=0 immediately. With FETCH_COUNT_EN, fetch_count=0; after 5 accepted handshakes, fetch_count=5.
